// File: rtl/sbox_lane_pipe.sv
// Pipelined AES SubBytes/InvSubBytes engine: LANES byte lanes per transaction, per-transaction mode,
// elastic valid/ready stages with registered outputs.
module sbox_lane_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [8*LANES-1:0] out_data
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    // One shared field inverter per lane; the affine maps wrap it on the appropriate side.
    function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
        logic [7:0] pre;
        logic [7:0] g;
        pre = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
        g   = gf_inv(pre);
        return inv ? g : (g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]}
                          ^ {g[3:0], g[7:4]} ^ 8'h63);
    endfunction

    logic               w_out_load;
    logic               w_src_valid;
    logic               w_src_inv;
    logic [8*LANES-1:0] w_src_data;
    logic [8*LANES-1:0] w_lk_data;

    logic               r_out_valid;
    logic               r_out_inv;
    logic [8*LANES-1:0] r_out_data;

    assign w_out_load = !r_out_valid || out_ready;

    generate
        if (STAGES >= 2) begin : g_two_stage
            logic               r_s0_valid;
            logic               r_s0_inv;
            logic [8*LANES-1:0] r_s0_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s0_valid <= 1'b0;
                    r_s0_inv   <= 1'b0;
                    r_s0_data  <= '0;
                end else if (flush) begin
                    r_s0_valid <= 1'b0;
                end else if (in_ready) begin
                    r_s0_valid <= in_valid;
                    if (in_valid) begin
                        r_s0_inv  <= in_inv;
                        r_s0_data <= in_data;
                    end
                end
            end

            assign in_ready    = !r_s0_valid || w_out_load;
            assign w_src_valid = r_s0_valid;
            assign w_src_inv   = r_s0_inv;
            assign w_src_data  = r_s0_data;
        end else begin : g_one_stage
            assign in_ready    = w_out_load;
            assign w_src_valid = in_valid;
            assign w_src_inv   = in_inv;
            assign w_src_data  = in_data;
        end
    endgenerate

    always_comb begin
        w_lk_data = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_lk_data[8*i +: 8] = sub_byte(w_src_data[8*i +: 8], w_src_inv);
        end
    end

    // Data registers load only on a real transfer so held outputs stay stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inv   <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= w_src_valid;
            if (w_src_valid) begin
                r_out_inv  <= w_src_inv;
                r_out_data <= w_lk_data;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inv   = r_out_inv;
    assign out_data  = r_out_data;

endmodule

// File: doc/sbox_lane_pipe.md
Name: sbox_lane_pipe

Overview:
- Parametrised, pipelined AES byte-substitution engine: applies forward S-box (SubBytes) or inverse S-box (InvSubBytes) to LANES bytes per transaction.
- Sits between the round-state register and ShiftRows/MixColumns in the round datapath, and can also be shared by key expansion (SubWord, LANES=4).
- Replaces fixed two-byte, forward-only combinational lookup with per-transaction mode select, valid/ready flow control and registered outputs.

Parameters:
- LANES, 4, number of byte lanes processed in parallel; legal 1..16.
- STAGES, 1, pipeline depth; legal 1 or 2. 1 = lookup then register; 2 = register input, then lookup, then register.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all in-flight transactions.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept the input transaction this cycle.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data.
- in_data  in  8*LANES  lane i = in_data[8i+7:8i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_inv  out  1  mode that produced out_data.
- out_data  out  8*LANES  substituted bytes, same lane order.

Behaviour:
- Reset (rst high, async): all stage valid bits = 0; out_valid=0, out_data=0, out_inv=0; in_ready=1 once rst deasserts. Internal data registers are reset to 0.
- Tables: forward = FIPS-197 S-box; inverse = FIPS-197 inverse S-box. Each lane gets an independent lookup. No default/X outputs; all 256 entries are defined for both tables.
- Mode: in_inv applies to all lanes of its transaction and travels with it. Consecutive transactions may alternate modes with no bubble.
- Handshake: a transfer occurs on a cycle where valid and ready are both 1. in_data/in_inv are captured only on an input transfer. out_data/out_inv hold stable while out_valid=1 and out_ready=0.
- Pipeline: elastic, one valid bit per stage. A stage loads when it is empty or its contents move forward in the same cycle.
  - in_ready = !v0 | (stage 0 advances this cycle).
  - The last stage advances when out_ready=1.
  - in_ready is combinationally dependent on out_ready. No combinational path exists from in_data to out_data.
- Latency: STAGES cycles from input transfer to out_valid, given no backpressure. Throughput is 1 transaction/cycle at full occupancy.
- Full condition: all stages valid and out_ready=0 -> in_ready=0. Stalls do not lose or duplicate data.
- Simultaneous events: stage full, out_ready=1 and in_valid=1 in the same cycle -> output transfers and the new input is accepted in that cycle.
- flush:
  - Clears all valid bits at the next edge. out_valid=0 and in_ready=1 on the following cycle.
  - An input presented during the flush cycle is discarded, even if in_ready was 1.
  - flush has priority over every advance.
- Reset mid-operation: all in-flight data is discarded immediately (async). The first transaction after rst deasserts behaves as it would from a clean start.

Test Plan:
- LANES=4, STAGES=1, in_inv=0, in_data=32'hFF53_0100 (lane0=00), out_ready=1 -> one cycle later out_valid=1, out_data=32'h16ED_7C63, out_inv=0.
- Same bench, in_inv=1, in_data=32'h16ED_7C63 -> out_data=32'hFF53_0100, out_inv=1. Then run all 256 byte values through lane 0 in both modes and check against the golden FIPS-197 tables; check InvS(S(x))=x.
- STAGES=2, back-to-back stream of 8 transactions with alternating in_inv -> outputs appear in order starting 2 cycles after the first input, one per cycle, each out_inv matching its input.
- STAGES=2, hold out_ready=0 for 5 cycles with in_valid=1 continuously -> in_ready falls after 2 accepts and out_data stays stable. Releasing out_ready -> no loss and no duplication; scoreboard matches.
- Assert flush with 2 transactions in flight and in_valid=1 -> out_valid=0 the next cycle, the flush-cycle input does not appear, and the next accepted input produces a correct result.
- Assert rst asynchronously mid-stream (between edges) -> out_valid and out_data go to 0 immediately. After rst deasserts, in_ready=1 and a new in_data=8'h53 (LANES=1) yields 8'hED.
